// File: rtl/instr_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_mem_arbiter                                            |
// | Description : Shares one instruction memory between two instruction-side  |
// |               masters over a req/gnt/rvalid protocol. One master is       |
// |               forwarded per memory grant. The owner of every granted      |
// |               request is kept in an in-order FIFO so that responses can   |
// |               be routed back to the right master.                         |
// | Ports       : clk, rst_n (async, active low)                              |
// |               m0_*/m1_*  : master side (req, addr, gnt, rvalid, rdata)    |
// |               mem_*      : memory side (req, addr, gnt, rvalid, rdata)    |
// |               proto_err_o: sticky, rvalid seen with nothing outstanding   |
// | Option      : IMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;    |
// |               if it is undefined, master 0 has fixed priority.            |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module instr_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  proto_err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] c_max_cnt  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_owner;
  logic               w_owner_nxt;
  logic               w_winner;
  logic               w_sel;
  logic               w_mem_req;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_head;
  logic               r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_proto_err;

  // --------------------------------------------------------------------------
  // Arbitration (only consulted in IDLE; LOCK uses the registered owner)
  // --------------------------------------------------------------------------
`ifdef IMEM_ARB_ROUND_ROBIN_EN
  logic r_last_gnt;

  always_comb begin
    if (m0_req_i && m1_req_i) begin
      w_winner = ~r_last_gnt;
    end else begin
      w_winner = ~m0_req_i;
    end
  end

  // Resets to 1 so that master 0 wins the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (w_push) begin
      r_last_gnt <= w_sel;
    end
  end
`else
  assign w_winner = ~m0_req_i;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_sel       = w_winner;
    w_mem_req   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Requests are only issued when a FIFO slot is free, so entering LOCK
        // implicitly reserves that slot. Reset masks the request so the
        // memory sees nothing while rst_n is low.
        w_mem_req = rst_n & (m0_req_i | m1_req_i) & ~w_full;
        if (w_mem_req && !mem_gnt_i) begin
          w_state_nxt = ST_LOCK;
          w_owner_nxt = w_winner;
        end
      end
      ST_LOCK: begin
        // Held even if the owner drops req: the memory already saw it.
        w_sel     = r_owner;
        w_mem_req = 1'b1;
        if (mem_gnt_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Owner FIFO
  // --------------------------------------------------------------------------
  assign w_full  = (r_count == c_max_cnt);
  assign w_empty = (r_count == '0);
  assign w_push  = mem_gnt_i & w_mem_req;
  assign w_pop   = mem_rvalid_i & ~w_empty;
  assign w_head  = r_fifo[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo   <= '{default: 1'b0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr         <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A response with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if (mem_rvalid_i && w_empty) begin
      r_proto_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_req_o   = w_mem_req;
  assign mem_addr_o  = w_mem_req ? (w_sel ? m1_addr_i : m0_addr_i) : '0;
  assign m0_gnt_o    = w_push & ~w_sel;
  assign m1_gnt_o    = w_push &  w_sel;
  assign m0_rvalid_o = w_pop  & ~w_head;
  assign m1_rvalid_o = w_pop  &  w_head;
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;
  assign proto_err_o = r_proto_err;

endmodule
`default_nettype wire
